// File: rtl/kf_gain_div_pkg.sv
// kf_gain_div_pkg
//   Shared fixed-point format macros, FSM state encodings, and the operand
//   classifier for the Kalman-gain divider.
//   The FXP_* macros are the codebase Q-format defaults. FXP_ONE is defined
//   here next to them, so the downstream update equation derives its ONE the
//   same way.
//   No ports (package).

`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif
`ifndef FXP_ONE
`define FXP_ONE (1 << `FXP_FRAC)
`endif

package kf_gain_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // How an accepted operand pair resolves. Only CLS_DIV runs the divider.
  typedef enum logic [1:0] {
    CLS_DIV   = 2'd0,
    CLS_BAD_D = 2'd1,
    CLS_ZERO  = 2'd2,
    CLS_SAT   = 2'd3
  } cls_e;

  // The checks run in priority order. The operands arrive sign-extended to
  // 64 bits, so one function serves every word width below 64.
  function automatic cls_e classify(input logic signed [63:0] p,
                                    input logic signed [63:0] d);
    if (d <= 64'sd0)
      return CLS_BAD_D;
    else if (p <= 64'sd0)
      return CLS_ZERO;
    else if (p >= d)
      return CLS_SAT;
    else
      return CLS_DIV;
  endfunction

endpackage

// File: rtl/kf_gain_div_udiv_step.sv
// fxp_udiv_step
//   One combinational restoring-division step. The module shifts the partial
//   remainder left by one bit and subtracts the divisor when the divisor
//   fits.
//   Ports:
//     rem      in  W : partial remainder (unsigned)
//     d        in  W : divisor (unsigned, > 0)
//     rem_next out W : remainder after this step
//     qbit     out 1 : quotient bit produced by this step

module fxp_udiv_step #(
  parameter int W = 18
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] d,
  output logic [W-1:0] rem_next,
  output logic         qbit
);

  logic [W-1:0] shifted;

  // The top bit dropped by this shift is always zero: rem < d stays true
  // throughout the divide, and d fits in W-1 bits.
  assign shifted  = {rem[W-2:0], 1'b0};
  assign qbit     = (shifted >= d);
  assign rem_next = qbit ? (shifted - d) : shifted;

endmodule

// File: rtl/kf_gain_div.sv
// kf_gain_div
//   Kalman gain K = P / (P + R) in Q(N,FRAC). The quotient comes from a
//   FRAC-step restoring divider. K is saturated to [0, ONE] so the
//   consumer's (1 - K) term never goes negative. Both sides use a
//   valid/ready handshake.
//   Ports:
//     clk       in  1 : rising-edge clock
//     rst       in  1 : asynchronous active-high reset
//     in_valid  in  1 : P/R valid
//     in_ready  out 1 : block is idle and accepts operands
//     P         in  N : predicted covariance (signed)
//     R         in  N : measurement noise (signed)
//     out_valid out 1 : K/err valid, held until out_ready
//     out_ready in  1 : consumer takes the result
//     K         out N : gain, 0..ONE
//     err       out 1 : the denominator was <= 0

module kf_gain_div
  import kf_gain_div_pkg::*;
#(
  parameter int N    = `FXP_N,
  parameter int FRAC = `FXP_FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] P,
  input  logic signed [N-1:0] R,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] K,
  output logic                err
);

  localparam int CW = (FRAC > 1) ? $clog2(FRAC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAC - 1);
  localparam logic signed [N-1:0] K_ONE = N'(1 << FRAC);

  logic [1:0]          state;
  cls_e                cls_in;
  cls_e                cls_q;
  logic signed [N:0]   d_sum;
  logic signed [63:0]  p_ext;
  logic signed [63:0]  d_ext;
  logic [N+1:0]        rem_q;
  logic [N+1:0]        d_q;
  logic [N+1:0]        rem_nxt;
  logic                qbit;
  logic [FRAC-1:0]     q_q;
  logic [FRAC-1:0]     q_nxt;
  logic [CW-1:0]       cnt_q;

  // The sum is one bit wider than the operands, so it never wraps.
  assign d_sum  = {P[N-1], P} + {R[N-1], R};
  assign p_ext  = {{(64-N){P[N-1]}}, P};
  assign d_ext  = {{(63-N){d_sum[N]}}, d_sum};
  assign cls_in = classify(p_ext, d_ext);

  assign in_ready = (state == ST_IDLE);

  fxp_udiv_step #(.W(N + 2)) u_step (
    .rem      (rem_q),
    .d        (d_q),
    .rem_next (rem_nxt),
    .qbit     (qbit)
  );

  assign q_nxt = {q_q[FRAC-2:0], qbit};

  // Special cases also pass through DIV for one cycle before reaching DONE.
  // Their result therefore appears one edge after accept, and the minimum
  // initiation interval is three cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cls_q     <= CLS_DIV;
      rem_q     <= '0;
      d_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      K         <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cls_q <= cls_in;
            rem_q <= {2'b00, P};
            d_q   <= {1'b0, d_sum};
            q_q   <= '0;
            cnt_q <= CNT_LAST;
            state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (cls_q != CLS_DIV) begin
            K         <= (cls_q == CLS_SAT) ? K_ONE : '0;
            err       <= (cls_q == CLS_BAD_D);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            rem_q <= rem_nxt;
            q_q   <= q_nxt;
            if (cnt_q == '0) begin
              K         <= {{(N-FRAC){1'b0}}, q_nxt};
              err       <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf_gain_div.sv
module tb_kf_gain_div;

  localparam int N    = 16;
  localparam int FRAC = 8;
  localparam int ONE  = 1 << FRAC;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [N-1:0] P = '0;
  logic signed [N-1:0] R = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [N-1:0] K;
  logic                err;

  kf_gain_div #(.N(N), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .K         (K),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int err;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic ov_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int p, input int r);
    exp_t e;
    int d;
    d = p + r;
    e.acc = 0;
    e.lat = 1;
    e.err = 0;
    if (d <= 0) begin
      e.k = 0;
      e.err = 1;
    end else if (p <= 0) begin
      e.k = 0;
    end else if (p >= d) begin
      e.k = ONE;
    end else begin
      e.k = (p * ONE) / d;
      e.lat = FRAC;
    end
    return e;
  endfunction

  // Called at a negedge. It returns at the negedge after the accept edge.
  task automatic send(input int p, input int r);
    exp_t e;
    int n;
    in_valid = 1'b1;
    P = N'(p);
    R = N'(r);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(p, r);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // Samples just after each negedge, once the main process has finished
  // driving inputs for that edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (out_valid && !ov_q) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("latency", cyc - sb[0].acc, sb[0].lat);
    end
    if (out_valid && out_ready) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("k", int'(K), e.k);
        chk("err", int'(err), e.err);
      end
    end
    ov_q = out_valid;
  end

  int tp[6] = '{256, 256, 100, 0, 256, 256};
  int tr[6] = '{256, 768, 200, 256, 0, -512};

  initial begin
    exp_t bp;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_k", int'(K), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_in_ready_rel", int'(in_ready), 1);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tp[i], tr[i]);
      drain();
    end

    // Backpressure: the result must hold and a stray in_valid must be ignored.
    out_ready = 1'b0;
    send(300, 500);
    bp = model(300, 500);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_k_hold", int'(K), bp.k);
      chk("bp_in_ready", int'(in_ready), 0);
      if (i == 1) begin
        in_valid = 1'b1;
        P = 16'sd256;
        R = 16'sd256;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_out_valid", int'(out_valid), 0);
    send(256, 256);
    drain();

    // Asynchronous reset in the middle of a division, at cnt == 3.
    send(256, 256);
    repeat (FRAC - 1 - 3) @(negedge clk);
    chk("pre_rst_out_valid", int'(out_valid), 0);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_k", int'(K), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    send(256, 256);
    drain();

    // Back-to-back random sweep with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      send(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
